// File: rtl/pe_grid_pkg.sv
// Shared types and saturating arithmetic for the output-stationary PE grid.
// The wide intermediate type lets one adder serve every accumulator width up to 63 bits.
package pe_grid_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    wide_t sum;
    logic  sat;
  } sat_res_t;

  function automatic wide_t acc_max(input int acc_w);
    return (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t acc_min(input int acc_w);
    return -(wide_t'(1) <<< (acc_w - 1));
  endfunction

  function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int acc_w);
    sat_res_t r;
    wide_t    s;
    s     = a + b;
    r.sum = s;
    r.sat = 1'b0;
    if (s > acc_max(acc_w)) begin
      r.sum = acc_max(acc_w);
      r.sat = 1'b1;
    end else if (s < acc_min(acc_w)) begin
      r.sum = acc_min(acc_w);
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_grid_os_cell.sv
// One processing element: registers and forwards its operands, and accumulates
// act*wt into a saturating accumulator with a sticky clamp flag.
module pe_mac_cell
  import pe_grid_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic signed [DATA_WIDTH-1:0] act_i,
  input  logic signed [DATA_WIDTH-1:0] wt_i,
  output logic signed [DATA_WIDTH-1:0] act_o,
  output logic signed [DATA_WIDTH-1:0] wt_o,
  output logic signed [ACC_WIDTH-1:0]  acc_o,
  output logic                         sat_o
);

  logic signed [DATA_WIDTH-1:0]   act_q, wt_q;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                           sat_q, sat_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  sat_res_t                       res;

  assign prod = act_i * wt_i;

  always_comb begin
    res   = sat_add(wide_t'(acc_q), wide_t'(prod), ACC_WIDTH);
    acc_d = res.sum[ACC_WIDTH-1:0];
    sat_d = sat_q | res.sat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= '0;
      wt_q  <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      act_q <= '0;
      wt_q  <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (en_i) begin
      act_q <= act_i;
      wt_q  <= wt_i;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign act_o = act_q;
  assign wt_o  = wt_q;
  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/pe_grid_os.sv
// Output-stationary systolic MAC grid: skewed operands ripple through ROWS x COLS
// cells on each accepted beat, then a zero flush and a row-by-row drain.
module pe_grid_os
  import pe_grid_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int K_WIDTH    = 10,
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [K_WIDTH-1:0]        k_len,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] act_in,
  input  logic [COLS*DATA_WIDTH-1:0] wt_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*ACC_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]          out_row,
  output logic                      out_last,
  output logic                      sat_flag
);

  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int FL_W      = (ROWS + COLS > 2) ? $clog2(ROWS + COLS) : 1;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
  logic [FL_W-1:0]    fl_cnt_q, fl_cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               done_q, done_d;
  logic               grid_en, grid_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_cnt_q  <= '0;
      fl_cnt_q <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_cnt_q  <= k_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      row_q    <= row_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_cnt_d   = k_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    row_d     = row_q;
    done_d    = 1'b0;
    grid_en   = 1'b0;
    grid_clr  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          grid_clr = 1'b1;
          k_cnt_d  = k_len;
          row_d    = '0;
          state_d  = (k_len != '0) ? COMPUTE : DRAIN;
        end
      end
      COMPUTE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          grid_en = 1'b1;
          k_cnt_d = k_cnt_q - 1'b1;
          if (k_cnt_q == K_WIDTH'(1)) begin
            fl_cnt_d = FL_W'(FLUSH_LEN);
            state_d  = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
          end
        end
      end
      FLUSH: begin
        grid_en  = 1'b1;
        fl_cnt_d = fl_cnt_q - 1'b1;
        if (fl_cnt_q == FL_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == ROW_W'(ROWS - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign out_row  = row_q;
  assign out_last = out_valid && (row_q == ROW_W'(ROWS - 1));

  logic signed [DATA_WIDTH-1:0] act_w [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0] wt_w  [ROWS+1][COLS];
  logic signed [ACC_WIDTH-1:0]  acc_w [ROWS][COLS];
  logic                         sat_w [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] act_edge [ROWS];
  logic signed [DATA_WIDTH-1:0] wt_edge  [COLS];

  // Outside COMPUTE the edges inject zeros so the flush adds nothing.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    assign act_edge[r] = (state_q == COMPUTE) ? act_in[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign act_w[r][0] = act_edge[r];
    end else begin : g_chain
      logic signed [DATA_WIDTH-1:0] sk_q [r];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < r; d++) sk_q[d] <= '0;
        end else if (grid_clr) begin
          for (int d = 0; d < r; d++) sk_q[d] <= '0;
        end else if (grid_en) begin
          sk_q[0] <= act_edge[r];
          for (int d = 1; d < r; d++) sk_q[d] <= sk_q[d-1];
        end
      end
      assign act_w[r][0] = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    assign wt_edge[c] = (state_q == COMPUTE) ? wt_in[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign wt_w[0][c] = wt_edge[c];
    end else begin : g_chain
      logic signed [DATA_WIDTH-1:0] sk_q [c];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < c; d++) sk_q[d] <= '0;
        end else if (grid_clr) begin
          for (int d = 0; d < c; d++) sk_q[d] <= '0;
        end else if (grid_en) begin
          sk_q[0] <= wt_edge[c];
          for (int d = 1; d < c; d++) sk_q[d] <= sk_q[d-1];
        end
      end
      assign wt_w[0][c] = sk_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      pe_mac_cell #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_cell (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (grid_en),
        .clr_i (grid_clr),
        .act_i (act_w[r][c]),
        .wt_i  (wt_w[r][c]),
        .act_o (act_w[r][c+1]),
        .wt_o  (wt_w[r+1][c]),
        .acc_o (acc_w[r][c]),
        .sat_o (sat_w[r][c])
      );
    end
  end

  always_comb begin
    sat_flag = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        sat_flag = sat_flag | sat_w[r][c];
  end

  always_comb begin
    out_data = '0;
    if (state_q == DRAIN)
      for (int c = 0; c < COLS; c++)
        out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_q][c];
  end

endmodule

// File: tb/tb_pe_grid_os.sv
// Directed bench for a 2x2 grid with 16-bit accumulators; each task drives one
// scenario and compares against hand-computed tile results.
module tb_pe_grid_os;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KW   = 10;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [KW-1:0]         k_len = '0;
  logic                  busy, done, in_ready, out_valid, out_last, sat_flag;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [ROWS*DW-1:0]    act_in = '0;
  logic [COLS*DW-1:0]    wt_in = '0;
  logic [COLS*AW-1:0]    out_data;
  logic [0:0]            out_row;

  int tests = 0;
  int fails = 0;
  logic signed [AW-1:0] exp_c [ROWS][COLS];

  always #5 clk = ~clk;

  pe_grid_os #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wt_in(wt_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .sat_flag(sat_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A=[[1,2],[3,4]], W=[[5,6],[7,8]]; lane 0 in the low byte
  localparam logic [15:0] A_B0 = {8'd3, 8'd1};
  localparam logic [15:0] A_B1 = {8'd4, 8'd2};
  localparam logic [15:0] W_B0 = {8'd6, 8'd5};
  localparam logic [15:0] W_B1 = {8'd8, 8'd7};

  task automatic set_golden();
    exp_c[0][0] = 16'sd19; exp_c[0][1] = 16'sd22;
    exp_c[1][0] = 16'sd43; exp_c[1][1] = 16'sd50;
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] w);
    act_in = a; wt_in = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s timeout: out_valid=%b want 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    tests++;
    if ({busy, done, in_ready, out_valid, out_last, sat_flag} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, done, in_ready, out_valid, out_last, sat_flag});
    end
    tests++;
    if (out_data !== '0 || out_row !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: data=%h row=%0d want 0", out_data, out_row);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cycles;
    set_golden();
    act_in = A_B0; wt_in = W_B0; in_valid = 1'b1;
    start = 1'b1; k_len = 10'd2;
    tick(); cycles = 1;
    start = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_compute: in_ready=%b busy=%b want 1 1", in_ready, busy);
    end
    tick(); cycles++;
    act_in = A_B1; wt_in = W_B1;
    tick(); cycles++;
    in_valid = 1'b0;
    while (!out_valid && cycles < 60) begin tick(); cycles++; end
    tests++;
    if (cycles != 1 + 2 + ROWS + COLS - 2) begin
      fails++;
      $display("FAIL basic_latency: got %0d want %0d", cycles, 1 + 2 + ROWS + COLS - 2);
    end
    for (int r = 0; r < ROWS; r++) begin
      tests++;
      if (out_valid !== 1'b1 || out_row !== 1'(r) || out_last !== (r == ROWS - 1)) begin
        fails++;
        $display("FAIL basic_row%0d: valid=%b row=%0d last=%b", r, out_valid, out_row, out_last);
      end
      for (int c = 0; c < COLS; c++) begin
        tests++;
        if ($signed(out_data[c*AW +: AW]) !== exp_c[r][c]) begin
          fails++;
          $display("FAIL basic_data r%0d c%0d: got %0d want %0d", r, c,
                   $signed(out_data[c*AW +: AW]), exp_c[r][c]);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: done=%b valid=%b want 1 0", done, out_valid);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_gaps();
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int         b = 0;
    set_golden();
    start = 1'b1; k_len = 10'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL gaps_in_ready cyc%0d: got %b want 1", i, in_ready);
      end
      in_valid = pat[i];
      act_in = (b == 0) ? A_B0 : A_B1;
      wt_in  = (b == 0) ? W_B0 : W_B1;
      if (pat[i]) b++;
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL gaps_flush_ready: got %b want 0", in_ready);
    end
    wait_valid("gaps");
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        tests++;
        if ($signed(out_data[c*AW +: AW]) !== exp_c[r][c] || out_row !== 1'(r)) begin
          fails++;
          $display("FAIL gaps_data r%0d c%0d: got %0d row %0d want %0d", r, c,
                   $signed(out_data[c*AW +: AW]), out_row, exp_c[r][c]);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL gaps_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_saturation();
    start = 1'b1; k_len = 10'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(16'h8080, 16'h8080);
    wait_valid("sat");
    tests++;
    if (sat_flag !== 1'b1) begin
      fails++;
      $display("FAIL sat_flag_set: got %b want 1", sat_flag);
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        tests++;
        if ($signed(out_data[c*AW +: AW]) !== 16'sd32767) begin
          fails++;
          $display("FAIL sat_data r%0d c%0d: got %0d want 32767", r, c,
                   $signed(out_data[c*AW +: AW]));
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tick();
    set_golden();
    start = 1'b1; k_len = 10'd2;
    tick();
    start = 1'b0;
    tests++;
    if (sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL sat_flag_clear: got %b want 0", sat_flag);
    end
    send_beat(A_B0, W_B0);
    send_beat(A_B1, W_B1);
    wait_valid("sat_next");
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        tests++;
        if ($signed(out_data[c*AW +: AW]) !== exp_c[r][c]) begin
          fails++;
          $display("FAIL sat_next_data r%0d c%0d: got %0d want %0d", r, c,
                   $signed(out_data[c*AW +: AW]), exp_c[r][c]);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL sat_next_flag: got %b want 0", sat_flag);
    end
    tick();
  endtask

  task automatic test_backpressure();
    set_golden();
    start = 1'b1; k_len = 10'd2;
    tick();
    start = 1'b0;
    send_beat(A_B0, W_B0);
    send_beat(A_B1, W_B1);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_row !== 1'b0 ||
          $signed(out_data[0 +: AW]) !== exp_c[0][0] ||
          $signed(out_data[AW +: AW]) !== exp_c[0][1]) begin
        fails++;
        $display("FAIL bp_hold cyc%0d: row=%0d d0=%0d d1=%0d want row 0 %0d %0d", i, out_row,
                 $signed(out_data[0 +: AW]), $signed(out_data[AW +: AW]),
                 exp_c[0][0], exp_c[0][1]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_row !== 1'b1 || out_last !== 1'b1 ||
        $signed(out_data[0 +: AW]) !== exp_c[1][0] ||
        $signed(out_data[AW +: AW]) !== exp_c[1][1]) begin
      fails++;
      $display("FAIL bp_row1: row=%0d last=%b d0=%0d d1=%0d want 1 1 %0d %0d", out_row, out_last,
               $signed(out_data[0 +: AW]), $signed(out_data[AW +: AW]),
               exp_c[1][0], exp_c[1][1]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: done=%b valid=%b want 1 0", done, out_valid);
    end
    tick();
  endtask

  task automatic test_k_zero();
    start = 1'b1; k_len = 10'd0; in_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== 1'(r) || out_data !== '0) begin
        fails++;
        $display("FAIL kzero_row%0d: ready=%b valid=%b row=%0d data=%h want 0 1 %0d 0",
                 r, in_ready, out_valid, out_row, out_data, r);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL kzero_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; k_len = 10'd2;
    tick();
    start = 1'b0;
    send_beat(A_B0, W_B0);
    rst = 1'b0;
    #2;
    tests++;
    if ({busy, in_ready, out_valid, done, sat_flag} !== 5'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: ctrl=%b data=%h want 0", {busy, in_ready, out_valid, done, sat_flag}, out_data);
    end
    tick();
    rst = 1'b1;
    tick();
    set_golden();
    start = 1'b1; k_len = 10'd2;
    tick();
    start = 1'b0;
    send_beat(A_B0, W_B0);
    send_beat(A_B1, W_B1);
    wait_valid("rstmid");
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        tests++;
        if ($signed(out_data[c*AW +: AW]) !== exp_c[r][c]) begin
          fails++;
          $display("FAIL rstmid_data r%0d c%0d: got %0d want %0d", r, c,
                   $signed(out_data[c*AW +: AW]), exp_c[r][c]);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_done: got %b want 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_backpressure();
    test_k_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_grid_os.md
Name: pe_grid_os

Overview:
- Parametrised output-stationary systolic MAC grid; successor to the broadcast PE array.
- Row activations enter at the left edge and weight columns at the top edge. Operands are skewed internally and pass PE-to-PE each cycle.
- Each PE keeps its own accumulator. A control FSM sequences compute, skew-flush and a row-by-row drain.
- Sits between the activation/weight buffers and the output-feature buffer. Computes one ROWS x COLS output tile per start.

Parameters:
- ROWS, 4, grid rows (activation lanes / output rows).
- COLS, 4, grid columns (weight lanes / output columns).
- DATA_WIDTH, 8, operand width, two's complement.
- ACC_WIDTH, 24, accumulator width; must be >= 2*DATA_WIDTH.
- K_WIDTH, 10, width of reduction-length input.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a tile; sampled only in IDLE.
- k_len  in  K_WIDTH  reduction length; sampled on accepted start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last drain beat.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- act_in  in  ROWS*DATA_WIDTH  lane r = A[r][k].
- wt_in  in  COLS*DATA_WIDTH  lane c = W[k][c].
- out_valid  out  1  drain row valid.
- out_ready  in  1  downstream accepts drain row.
- out_data  out  COLS*ACC_WIDTH  lane c = C[out_row][c].
- out_row  out  $clog2(ROWS)  row index of out_data.
- out_last  out  1  high with the final row (out_row == ROWS-1).
- sat_flag  out  1  sticky: any accumulator saturated this tile.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; all skew registers, PE operand registers and accumulators clear to 0.
  - busy, done, in_ready, out_valid, out_last, sat_flag, out_row and out_data are all 0.
- IDLE:
  - in_ready = 0.
  - On start: latch k_len, clear all accumulators and sat_flag, zero the beat counter.
  - Go to COMPUTE if k_len != 0, else go straight to DRAIN (tile of zeros).
  - start while busy is ignored.
- COMPUTE:
  - in_ready = 1.
  - The grid advances only on an accepted beat (global enable); with in_valid low, the grid holds and inserts no bubble.
  - On an accepted beat:
    - Row r lane enters a skew chain of depth r; column c lane enters a skew chain of depth c.
    - PE(r,c) takes its act from the left neighbour and its wt from the top neighbour, does acc += act*wt, and forwards both operands.
  - After k_len accepted beats, go to FLUSH.
- FLUSH:
  - in_ready = 0.
  - Grid enable is forced high for ROWS+COLS-2 cycles; zeros are injected at both edges.
  - Then go to DRAIN. When ROWS = COLS = 1, FLUSH lasts 0 cycles.
- DRAIN:
  - out_valid = 1; out_data shows accumulator row out_row, starting at row 0.
  - On out_valid && out_ready, out_row increments.
  - out_data and out_row hold stable while out_ready is low.
  - Beat with out_row = ROWS-1 has out_last = 1. After it is accepted: out_valid drops, done pulses for 1 cycle, FSM returns to IDLE.
- Arithmetic:
  - Product is a signed 2*DATA_WIDTH value, sign-extended to ACC_WIDTH+1.
  - The sum saturates to the signed ACC_WIDTH range (max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1)).
  - Any clamp sets sat_flag; it holds until the next accepted start or reset.
  - Zero operands injected during flush add nothing.
- Result: C[r][c] = sum over k=0..k_len-1 of A[r][k]*W[k][c], independent of in_valid gaps.
- Minimum latency, start to first out_valid: 1 + k_len + (ROWS+COLS-2) cycles (start-accept cycle, then k_len back-to-back beats, then FLUSH), with in_valid held high.
- Reset mid-operation aborts the tile. No done pulse; state is as after reset.

Decomposition:
- Package pe_grid_pkg holds the FSM state enum (IDLE, COMPUTE, FLUSH, DRAIN), the saturating-add function and the signed min/max constants derived from ACC_WIDTH.
- Sub-module pe_mac_cell: one PE with operand forwarding registers, enable, clear and a saturating accumulator. The grid instantiates ROWS*COLS of it.

Test Plan:
- 2x2 grid, k_len=2, A=[[1,2],[3,4]], W=[[5,6],[7,8]], in_valid held high -> rows out [19,22] then [43,50]; out_last on row 1; done one cycle after; first out_valid exactly 1+2+2 cycles after the start-accept cycle.
- Same tile, in_valid toggled 1,0,0,1 -> identical results; in_ready high throughout COMPUTE; no extra accumulation during gaps.
- DATA_WIDTH=8, ACC_WIDTH=16, k_len=4, all operands -128 -> each product +16384; result clamps to 32767; sat_flag=1; next start with small values clears sat_flag.
- out_ready held low 5 cycles during DRAIN -> out_data and out_row stable; resumes at the same row with no loss or duplication.
- k_len=0 -> no in_ready assertion; ROWS zero rows drained; done pulses.
- rst asserted during COMPUTE, then a new tile -> outputs zero immediately; next tile matches golden with no residue.
